// File: rtl/axi_arp_lookup_arb.sv
// Round-robin arbiter sharing the ARP IP-to-MAC lookup port among UDP TX clients.
// Optional lookup timeout is built when AXI_ARP_LOOKUP_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module axi_arp_lookup_arb #(
    parameter int          NUM_CLIENTS    = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic [NUM_CLIENTS-1:0]    cli_req,
    input  logic [NUM_CLIENTS*32-1:0] cli_ip,
    output logic [NUM_CLIENTS-1:0]    cli_done,
    output logic [NUM_CLIENTS-1:0]    cli_err,
    output logic [47:0]               cli_mac,
    output logic [31:0]               arp_lookup_ip,
    output logic                      arp_lookup_req,
    input  logic [47:0]               arp_lookup_mac,
    input  logic                      arp_lookup_valid
);
    localparam int IW = $clog2(NUM_CLIENTS);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_DONE} state_t;

    state_t        state;
    logic [IW-1:0] grant;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic [IW-1:0] next_ptr;
    logic          found;

    // First requester at or after rr_ptr, wrapping around
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_CLIENTS);
            if (!found && cli_req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign next_ptr = (grant == IW'(NUM_CLIENTS - 1)) ? '0 : grant + 1'b1;

`ifdef AXI_ARP_LOOKUP_ARB_TIMEOUT_EN
    logic [23:0]            tmo_cnt;
    logic [NUM_CLIENTS-1:0] err_q;
    assign cli_err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign cli_err    = '0;
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= S_IDLE;
            grant          <= '0;
            rr_ptr         <= '0;
            cli_done       <= '0;
            cli_mac        <= 48'h0;
            arp_lookup_ip  <= 32'h0;
            arp_lookup_req <= 1'b0;
`ifdef AXI_ARP_LOOKUP_ARB_TIMEOUT_EN
            tmo_cnt        <= 24'h0;
            err_q          <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant          <= pick;
                        arp_lookup_ip  <= cli_ip[int'(pick)*32 +: 32];
                        arp_lookup_req <= 1'b1;
                        state          <= S_LOOKUP;
`ifdef AXI_ARP_LOOKUP_ARB_TIMEOUT_EN
                        tmo_cnt        <= 24'h0;
`endif
                    end
                end
                S_LOOKUP: begin
                    if (arp_lookup_valid) begin
                        cli_mac         <= arp_lookup_mac;
                        cli_done[grant] <= 1'b1;
                        rr_ptr          <= next_ptr;
                        arp_lookup_req  <= 1'b0;
                        state           <= S_DONE;
                    end else if (!cli_req[grant]) begin
                        // Client gave up: silent abort
                        rr_ptr         <= next_ptr;
                        arp_lookup_req <= 1'b0;
                        state          <= S_IDLE;
`ifdef AXI_ARP_LOOKUP_ARB_TIMEOUT_EN
                    end else if (tmo_cnt >= TIMEOUT_CYCLES) begin
                        err_q[grant]   <= 1'b1;
                        rr_ptr         <= next_ptr;
                        arp_lookup_req <= 1'b0;
                        state          <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 24'd1;
`endif
                    end
                end
                S_DONE: begin
                    cli_done <= '0;
`ifdef AXI_ARP_LOOKUP_ARB_TIMEOUT_EN
                    err_q    <= '0;
`endif
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_arp_lookup_arb.md
# axi_arp_lookup_arb

Shares the single IP-to-MAC lookup port of the ARP engine between `NUM_CLIENTS` UDP transmit requesters. Pending requests are granted round-robin, one lookup at a time. The block holds the granted IP on the lookup port until the ARP engine reports a cached MAC, then returns that MAC to the requester with a one-cycle done pulse. An optional timeout aborts lookups that never resolve.

## Interface
- `NUM_CLIENTS`, 4: number of requesters; range 2..8.
- `TIMEOUT_CYCLES`, 24'd1000000: cycles in `S_LOOKUP` before the lookup is aborted; only used with timeout enabled; must be ≥ 1.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `aresetn` input 1: reset, asynchronous and active-low.
- `cli_req` input NUM_CLIENTS: per-client lookup request; level; held until that client's done/err.
- `cli_ip` input NUM_CLIENTS*32: per-client target IP; client i uses bits [32i+31:32i]; stable while `cli_req[i]` is high.
- `cli_done` output NUM_CLIENTS: one-cycle pulse; `cli_mac` is valid for client i.
- `cli_err` output NUM_CLIENTS: one-cycle pulse; lookup for client i timed out.
- `cli_mac` output 48: resolved MAC, shared by all clients; held until the next done.
- `arp_lookup_ip` output 32: IP presented to the ARP engine.
- `arp_lookup_req` output 1: lookup request to the ARP engine.
- `arp_lookup_mac` input 48: cached MAC from the ARP engine.
- `arp_lookup_valid` input 1: the ARP engine cache holds `arp_lookup_ip`. Combinational from `arp_lookup_ip`.

## Operation
- States: `S_IDLE`, `S_LOOKUP`, `S_DONE`.
- **`S_IDLE`**
  - If any `cli_req` is high, grant the first requester at or after `rr_ptr`, searching upward with wrap-around.
  - Register `grant` (index) and `arp_lookup_ip <= cli_ip[grant]`, then go to `S_LOOKUP`.
- **`S_LOOKUP`**
  - `arp_lookup_req` is high.
  - If `arp_lookup_valid`:
    - `cli_mac <= arp_lookup_mac`
    - `cli_done[grant] <= 1`
    - `rr_ptr <= grant+1` (mod `NUM_CLIENTS`)
    - go to `S_DONE`.
  - Else, if `cli_req[grant]` has dropped: abort with no done/err, advance `rr_ptr`, go to `S_IDLE`.
  - Else, with timeout enabled and the counter reaching `TIMEOUT_CYCLES`:
    - `cli_err[grant] <= 1`, advance `rr_ptr`, go to `S_DONE`.
- **`S_DONE`**
  - Single cycle; requests are ignored.
  - Clears the done/err pulses and returns to `S_IDLE`.
  - Clients must drop `cli_req` on the cycle they see `cli_done` or `cli_err`.
- **Priority in `S_LOOKUP`:** `arp_lookup_valid` beats a dropped request, which beats timeout.
- `cli_ip` changing while its request is granted is ignored; the registered IP is used.
- **Reset values:**
  - `cli_done`, `cli_err`, `arp_lookup_req` = 0
  - `cli_mac` = 48'h0, `arp_lookup_ip` = 32'h0
  - `rr_ptr` = 0, state `S_IDLE`.
- Reset asserted mid-lookup: everything returns to reset values immediately and asynchronously. No done/err is issued for the aborted lookup.

## Timing
- Fastest path with a cache hit:
  - Cycle 0: request seen in `S_IDLE`.
  - Cycle 1: `S_LOOKUP`, `arp_lookup_req` = 1, hit sampled.
  - Cycle 2: `cli_done` = 1.
  - Cycle 3: `S_IDLE`; the next grant is possible here.
- Back-to-back clients are served at one grant per 3 cycles minimum.
- `arp_lookup_req` and `arp_lookup_ip` are registered. `arp_lookup_req` rises 1 cycle after the grant and falls on the cycle after the hit is sampled.
- A cache miss makes the ARP engine broadcast a request. The lookup stays in `S_LOOKUP` until a reply fills the cache.
- Timeout counter:
  - 24-bit; cleared on entry to `S_LOOKUP`; increments every `S_LOOKUP` cycle.
  - `cli_err` pulses `TIMEOUT_CYCLES`+1 cycles after `arp_lookup_req` rises.
- `cli_done` and `cli_err` are never high together, and at most one bit of each is high in any cycle.

## Configuration
- Macro: `AXI_ARP_LOOKUP_ARB_TIMEOUT_EN`.
- **Defined:** the timeout counter and `cli_err` logic are present, as described above.
- **Undefined:**
  - No counter is built and `cli_err` is tied to 0.
  - `S_LOOKUP` waits indefinitely for a hit or for the request to drop.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- **Single hit:** client 1 requests IP c0a80601; the ARP model reports a hit immediately with MAC 0a0b0c0d0e0f. Required: `arp_lookup_ip` = c0a80601 at cycle 1, and `cli_done[1]` at cycle 2 with `cli_mac` = 0a0b0c0d0e0f.
- **Round-robin:** clients 0, 2 and 3 request together, each with a different IP, all hits. Required: done order 0, 2, 3, 3 cycles apart. Re-requesting client 0 after its done is served only after client 3.
- **Miss then fill:** client 2 requests; `arp_lookup_valid` is held low for 500 cycles, then high. Required: `arp_lookup_req` stays high throughout, then `cli_done[2]` pulses, with no `cli_err`.
- **Timeout:** with the macro defined and `TIMEOUT_CYCLES` = 100, the model never hits. Required: `cli_err[0]` pulses 101 cycles after `arp_lookup_req` rises, and `cli_done` stays 0. Without the macro, no err is ever raised.
- **Abort:** client 1 drops `cli_req` at lookup cycle 10 while the lookup is missing. Required: back in `S_IDLE` the next cycle, no done/err, and the pending client 2 is granted next.
- **Async reset:** `aresetn` pulled low mid-`S_LOOKUP`, between clock edges. Required: `arp_lookup_req`, `cli_done` and `cli_err` go to 0 immediately. After release, a new request for client 0 completes normally.
